// File: rtl/tank_pump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_pump_ctrl_pkg
// Brief    : Shared state encoding, fault-counter limit and pump scan helper.
// Revision : 1.0 - initial release
// ============================================================================
package tank_pump_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BOOST = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int FAULT_CNT_MAX = 255;
  localparam int MAX_PUMPS     = 8;

  // Select up to n_sel available pumps, scanning upward from ptr with wrap.
  function automatic logic [MAX_PUMPS-1:0] scan_unmasked(
    input logic [MAX_PUMPS-1:0] mask,
    input logic [2:0]           ptr,
    input int unsigned          n_pumps,
    input int unsigned          n_sel
  );
    logic [MAX_PUMPS-1:0] sel;
    int unsigned          cnt;
    int unsigned          idx;
    sel = '0;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_PUMPS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n_pumps) idx = idx - n_pumps;
      if ((i < n_pumps) && mask[idx[2:0]] && (cnt < n_sel)) begin
        sel[idx[2:0]] = 1'b1;
        cnt = cnt + 1;
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_pump_ctrl_sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Brief    : Filtered sensor level that follows the raw input only after it has
//            disagreed for DEB_CYCLES consecutive cycles. Filtered resets to 1.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam logic [7:0] c_limit = 8'(DEB_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else if (raw == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == c_limit) begin
      r_filt <= raw;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/tank_pump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tank_pump_ctrl
// Brief    : N-pump tank fill controller with boost, duty rotation, maintenance
//            mask and sensor-fault counting. Define TANK_PUMP_CTRL_DEBOUNCE_EN
//            to filter both sensors through sensor_debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tank_pump_ctrl
  import tank_pump_ctrl_pkg::*;
#(
  parameter int N_PUMPS     = 2,
  parameter int BOOST_PUMPS = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               I,
  input  logic               S,
  input  logic [N_PUMPS-1:0] pump_mask,
  output logic [N_PUMPS-1:0] pump_on,
  output logic [1:0]         state_o,
  output logic               fault,
  output logic [7:0]         fault_cnt
);

  logic                 r_i_q;
  logic                 r_s_q;
  logic                 w_lo;
  logic                 w_hi;
  state_t               r_state;
  state_t               w_state_next;
  logic [2:0]           r_ptr;
  logic [2:0]           w_ptr_next;
  logic [MAX_PUMPS-1:0] w_mask_ext;
  logic [MAX_PUMPS-1:0] w_scan_fill;
  logic [MAX_PUMPS-1:0] w_scan_boost;
  logic [N_PUMPS-1:0]   w_pump_next;
  logic                 w_advance;

  // Reset to "full" so no pump starts before the first real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_q <= 1'b1;
      r_s_q <= 1'b1;
    end else begin
      r_i_q <= I;
      r_s_q <= S;
    end
  end

`ifdef TANK_PUMP_CTRL_DEBOUNCE_EN
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (r_i_q),
    .filt  (w_lo)
  );
  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (r_s_q),
    .filt  (w_hi)
  );
`else
  assign w_lo = r_i_q;
  assign w_hi = r_s_q;
`endif

  always_comb begin
    w_state_next = r_state;
    if (!w_lo && w_hi) begin
      w_state_next = FAULT;
    end else begin
      case (r_state)
        IDLE:    if (!w_lo) w_state_next = BOOST;
        BOOST:   if (w_lo)  w_state_next = w_hi ? IDLE : FILL;
        FILL: begin
          if (w_hi)       w_state_next = IDLE;
          else if (!w_lo) w_state_next = BOOST;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_mask_ext   = MAX_PUMPS'(pump_mask);
  assign w_scan_fill  = scan_unmasked(w_mask_ext, r_ptr, N_PUMPS, 1);
  assign w_scan_boost = scan_unmasked(w_mask_ext, r_ptr, N_PUMPS, BOOST_PUMPS);

  always_comb begin
    w_pump_next = '0;
    case (w_state_next)
      FILL:    w_pump_next = w_scan_fill[N_PUMPS-1:0];
      BOOST:   w_pump_next = w_scan_boost[N_PUMPS-1:0];
      default: w_pump_next = '0;
    endcase
  end

  // Descending scan so the nearest available pump after ptr wins.
  always_comb begin
    int idx;
    w_ptr_next = r_ptr;
    for (int i = N_PUMPS - 1; i >= 1; i--) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_PUMPS) idx = idx - N_PUMPS;
      if (w_mask_ext[idx[2:0]]) w_ptr_next = idx[2:0];
    end
  end

  assign w_advance = ((r_state == FILL) || (r_state == BOOST)) && (w_state_next == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      pump_on   <= '0;
      fault     <= 1'b0;
      fault_cnt <= '0;
      r_ptr     <= '0;
    end else begin
      r_state <= w_state_next;
      pump_on <= w_pump_next;
      fault   <= (w_state_next == FAULT);
      if ((w_state_next == FAULT) && (r_state != FAULT) && (fault_cnt != 8'(FAULT_CNT_MAX)))
        fault_cnt <= fault_cnt + 8'd1;
      if (w_advance)
        r_ptr <= w_ptr_next;
    end
  end

  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tank_pump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_pump_ctrl
// Brief    : Directed self-checking bench for tank_pump_ctrl (2 pumps, boost 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tank_pump_ctrl;

  localparam int DEB = 4;
`ifdef TANK_PUMP_CTRL_DEBOUNCE_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BOOST = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       I;
  logic       S;
  logic [1:0] pump_mask;
  logic [1:0] pump_on;
  logic [1:0] state_o;
  logic       fault;
  logic [7:0] fault_cnt;

  int n_cmp = 0;
  int n_err = 0;

  tank_pump_ctrl #(.N_PUMPS(2), .BOOST_PUMPS(2), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I         (I),
    .S         (S),
    .pump_mask (pump_mask),
    .pump_on   (pump_on),
    .state_o   (state_o),
    .fault     (fault),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] e_pump,
                           input logic [1:0] e_state, input logic e_fault);
    check({tag, ".pump_on"}, 8'(pump_on), 8'(e_pump));
    check({tag, ".state"},   8'(state_o), 8'(e_state));
    check({tag, ".fault"},   8'(fault),   8'(e_fault));
  endtask

  task automatic set_sensors(input logic i_v, input logic s_v);
    I = i_v;
    S = s_v;
  endtask

  initial begin
    rst_n = 1'b0;
    set_sensors(1'b1, 1'b1);
    pump_mask = 2'b11;
    tick(2);
    check_out("reset_held", 2'b00, ST_IDLE, 1'b0);
    check("reset_held.cnt", fault_cnt, 8'd0);
    rst_n = 1'b1;
    tick(LAT);
    check_out("idle_after_reset", 2'b00, ST_IDLE, 1'b0);

    // Drain below low mark: boost after the pipeline latency, not before.
    set_sensors(1'b0, 1'b0);
    tick(LAT - 1);
    check_out("boost_not_yet", 2'b00, ST_IDLE, 1'b0);
    tick(1);
    check_out("boost1", 2'b11, ST_BOOST, 1'b0);
    set_sensors(1'b1, 1'b0);
    tick(LAT);
    check_out("fill_ptr0", 2'b01, ST_FILL, 1'b0);
    set_sensors(1'b1, 1'b1);
    tick(LAT);
    check_out("idle1", 2'b00, ST_IDLE, 1'b0);

    // Rotation: ptr is now 1.
    set_sensors(1'b0, 1'b0);
    tick(LAT);
    check_out("boost2", 2'b11, ST_BOOST, 1'b0);
    set_sensors(1'b1, 1'b0);
    tick(LAT);
    check_out("fill_ptr1", 2'b10, ST_FILL, 1'b0);
    set_sensors(1'b1, 1'b1);
    tick(LAT);
    check_out("idle2", 2'b00, ST_IDLE, 1'b0);

    // Mask changes mid-FILL with ptr back at 0.
    set_sensors(1'b0, 1'b0);
    tick(LAT);
    set_sensors(1'b1, 1'b0);
    tick(LAT);
    check_out("fill_ptr0b", 2'b01, ST_FILL, 1'b0);
    pump_mask = 2'b10;
    tick(1);
    check_out("mask_10", 2'b10, ST_FILL, 1'b0);
    pump_mask = 2'b00;
    tick(1);
    check_out("mask_00", 2'b00, ST_FILL, 1'b0);
    pump_mask = 2'b11;
    tick(1);
    check_out("mask_11", 2'b01, ST_FILL, 1'b0);

    // Inconsistent sensors from FILL.
    set_sensors(1'b0, 1'b1);
    tick(LAT);
    check_out("fault1", 2'b00, ST_FAULT, 1'b1);
    check("fault1.cnt", fault_cnt, 8'd1);
    tick(4);
    check("fault_hold.cnt", fault_cnt, 8'd1);
    set_sensors(1'b1, 1'b1);
    tick(LAT);
    check_out("fault_clear", 2'b00, ST_IDLE, 1'b0);
    check("fault_clear.cnt", fault_cnt, 8'd1);

    // FILL->FAULT->IDLE must not have rotated: FILL still starts at pump 0.
    set_sensors(1'b0, 1'b0);
    tick(LAT);
    set_sensors(1'b1, 1'b0);
    tick(LAT);
    check_out("fill_after_fault", 2'b01, ST_FILL, 1'b0);
    set_sensors(1'b1, 1'b1);
    tick(LAT);

    // ptr=1 with only pump 0 available: boost degrades, FILL wraps, ptr wraps to 0.
    pump_mask = 2'b01;
    set_sensors(1'b0, 1'b0);
    tick(LAT);
    check_out("boost_one_avail", 2'b01, ST_BOOST, 1'b0);
    set_sensors(1'b1, 1'b0);
    tick(LAT);
    check_out("fill_wrap", 2'b01, ST_FILL, 1'b0);
    set_sensors(1'b1, 1'b1);
    tick(LAT);
    pump_mask = 2'b11;
    set_sensors(1'b0, 1'b0);
    tick(LAT);
    set_sensors(1'b1, 1'b0);
    tick(LAT);
    check_out("fill_ptr_wrapped", 2'b01, ST_FILL, 1'b0);
    set_sensors(1'b1, 1'b1);
    tick(LAT);

    // Fault counter saturation: 1 entry so far.
    for (int k = 0; k < 253; k++) begin
      set_sensors(1'b0, 1'b1);
      tick(LAT);
      set_sensors(1'b1, 1'b1);
      tick(LAT);
    end
    check("cnt_254", fault_cnt, 8'd254);
    for (int k = 0; k < 47; k++) begin
      set_sensors(1'b0, 1'b1);
      tick(LAT);
      set_sensors(1'b1, 1'b1);
      tick(LAT);
    end
    check("cnt_sat", fault_cnt, 8'd255);
    check_out("after_sat", 2'b00, ST_IDLE, 1'b0);

`ifdef TANK_PUMP_CTRL_DEBOUNCE_EN
    // Glitch one cycle shorter than the window is ignored.
    set_sensors(1'b0, 1'b1);
    S = 1'b1;
    I = 1'b0;
    set_sensors(1'b0, 1'b0);
    tick(DEB - 1);
    set_sensors(1'b1, 1'b0);
    tick(DEB + 4);
    check_out("deb_short", 2'b00, ST_IDLE, 1'b0);
    set_sensors(1'b1, 1'b1);
    tick(DEB + 2);
    // Pulse exactly DEB cycles long reaches BOOST at DEB+2.
    set_sensors(1'b0, 1'b0);
    tick(DEB);
    set_sensors(1'b1, 1'b1);
    tick(DEB + 1 - DEB);
    check_out("deb_pre", 2'b00, ST_IDLE, 1'b0);
    tick(1);
    check_out("deb_boost", 2'b11, ST_BOOST, 1'b0);
    tick(3 * DEB);
    check_out("deb_settle", 2'b00, ST_IDLE, 1'b0);
`endif

    // Asynchronous reset between edges in the middle of BOOST.
    set_sensors(1'b0, 1'b0);
    tick(LAT);
    check_out("boost_pre_rst", 2'b11, ST_BOOST, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 2'b00, ST_IDLE, 1'b0);
    check("async_rst.cnt", fault_cnt, 8'd0);
    set_sensors(1'b1, 1'b1);
    tick(1);
    rst_n = 1'b1;
    tick(LAT);
    check_out("post_rst", 2'b00, ST_IDLE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
